systolic_operand_feeder: RTL
============================

Name: systolic_operand_feeder

Overview:
- Upstream stage of the 2x2 MAC array input-skew manager.
- Accepts one full A matrix and one full B matrix per job through a valid/ready handshake, then streams them as time-skewed lanes: A column lanes drive `new_a_column` and B row lanes drive `new_b_row`.
- Waits through drain cycles so the last operands reach the far MAC, then pulses `done`.
- Also issues an accumulator-clear pulse to the MAC array at job start.

Parameters:
- OP_WIDTH, 8, width of one matrix element in bits.
- N, 2, array dimension. Matrices are NxN. Default 2 matches the current array; RTL must stay generic in N >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_valid  in  1  job request; a_matrix/b_matrix are valid while high.
- start_ready  out  1  high only in IDLE; a job is accepted on any edge where start_valid && start_ready.
- a_matrix  in  N*N*OP_WIDTH  element A[i][k] at bits [(i*N+k)*OP_WIDTH +: OP_WIDTH].
- b_matrix  in  N*N*OP_WIDTH  element B[k][j] at bits [(k*N+j)*OP_WIDTH +: OP_WIDTH].
- new_a_column  out  N*OP_WIDTH  lane i at [i*OP_WIDTH +: OP_WIDTH]; feeds the MAC array's A input.
- new_b_row  out  N*OP_WIDTH  lane j at [j*OP_WIDTH +: OP_WIDTH]; feeds the MAC array's B input.
- feed_active  out  1  high during FEED cycles.
- acc_clear  out  1  one-cycle pulse, first FEED cycle.
- busy  out  1  high in FEED and DRAIN.
- done  out  1  one-cycle pulse at end of DRAIN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, captured matrices=0, all outputs 0 except start_ready=1. A reset mid-job aborts it immediately, with no done pulse.
- All outputs except start_ready are registered. start_ready = (state==IDLE).
- States: IDLE, FEED, DRAIN.
- IDLE -> FEED on accept edge:
  - capture a_matrix and b_matrix into internal registers;
  - set cnt t=0;
  - drive the t=0 lane values in the cycle following the accept edge;
  - acc_clear=1, feed_active=1 and busy=1 in that same cycle.
- FEED lasts exactly 2N-1 cycles (t=0..2N-2). In cycle t:
  - A lane i = A[i][t-i] if 0 <= t-i <= N-1, else 0;
  - B lane j = B[t-j][j] if 0 <= t-j <= N-1, else 0.
- FEED -> DRAIN after t=2N-2. In DRAIN:
  - lanes=0, feed_active=0, busy=1;
  - lasts exactly N cycles, so the last operand pair propagates to MAC(N-1,N-1).
- DRAIN -> IDLE:
  - done=1 for exactly the first IDLE cycle;
  - busy=0 and start_ready=1 in that same cycle, so a new job may be accepted at the end of the done cycle.
- Total job length: accept edge to done high is 3N cycles.
- Counter width: clog2(2N). No wrap is possible; the counter resets to 0 on each state change.
- Element arithmetic: none. Values pass through unmodified and zero padding is exact zero.
- start_valid while busy: ignored. Input matrices may change after the accept edge without affecting the job.
- acc_clear is never asserted outside the first FEED cycle. done and acc_clear are never high together.

Decomposition:
- Shared package tpu_pkg holds:
  - typedef op_t (logic [OP_WIDTH-1:0]);
  - feeder state enum {IDLE, FEED, DRAIN};
  - localparams FEED_CYCLES=2N-1 and DRAIN_CYCLES=N.
- One natural sub-module: skew_lane_select. It is combinational; given captured matrix, t and lane index it returns the element or 0. It is instantiated 2N times (N for A as row-major, N for B as column-major via an index-swap parameter).
- FSM and counter stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start_valid=1 -> all outputs 0 except start_ready=1, and no job is accepted.
- Basic 2x2 job: A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  - Required lane sequence after the accept edge, for 3 FEED cycles:
    - a=(1,0), b=(5,0);
    - a=(2,3), b=(7,6);
    - a=(0,4), b=(0,8).
  - Then 2 DRAIN cycles with all lanes 0, then done=1.
  - acc_clear is high only in the first FEED cycle.
  - With the MAC array attached, accumulators read [[19,22],[43,50]].
- Busy rejection: assert start_valid with different matrices throughout FEED/DRAIN -> start_ready=0, lane values unchanged from the basic job, exactly one done.
- Back-to-back: keep start_valid=1 -> second job accepted at the edge ending the done cycle; its first FEED cycle immediately follows, and the 3N-cycle job period is confirmed.
- Mid-job reset: drive reset=0 during the second FEED cycle -> lanes, busy and feed_active go 0 asynchronously, no done pulse, start_ready=1 after release.
- Max values with N=3: all elements 8'hFF -> lane i is nonzero exactly in FEED cycles i..i+2, and 0 elsewhere.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the TPU operand path.
package tpu_pkg;

    localparam int DEFAULT_OP_WIDTH = 8;
    localparam int DEFAULT_N        = 2;

    // Sizes for the default array; generic instances use the helpers below.
    localparam int FEED_CYCLES  = 2 * DEFAULT_N - 1;
    localparam int DRAIN_CYCLES = DEFAULT_N;

    typedef logic [DEFAULT_OP_WIDTH-1:0] op_t;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } feeder_state_t;

    // FEED must cover every skewed diagonal of an n x n array.
    function automatic int feed_cycles(input int n);
        return 2 * n - 1;
    endfunction

    // DRAIN lets the last operand pair ripple to MAC(n-1,n-1).
    function automatic int drain_cycles(input int n);
        return n;
    endfunction

endpackage

// File: rtl/skew_lane_select.sv
// Combinational pick of one skewed lane element from a packed NxN matrix.
// Row-major (COL_MAJOR=0): element M[LANE][t-LANE]  (A column lanes).
// Col-major (COL_MAJOR=1): element M[t-LANE][LANE]  (B row lanes).
// Outside the diagonal window the lane carries exact zero.
module skew_lane_select #(
    parameter int OP_WIDTH  = 8,
    parameter int N         = 2,
    parameter int CNT_W     = 2,
    parameter int LANE      = 0,
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic [N*N*OP_WIDTH-1:0] matrix,
    input  logic [CNT_W-1:0]        t,
    output logic [OP_WIDTH-1:0]     element
);

    localparam int IDX_W = $clog2(N * N * OP_WIDTH);

    // Select the element on this lane's diagonal, or zero padding.
    always_comb begin
        int                k;
        logic [IDX_W-1:0]  base;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        element = '0;
        base    = '0;
        k       = int'(t) - LANE;
        if (k >= 0 && k < N) begin
            if (COL_MAJOR) base = IDX_W'((k * N + LANE) * OP_WIDTH);
            else           base = IDX_W'((LANE * N + k) * OP_WIDTH);
            element = matrix[base +: OP_WIDTH];
        end
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Input-skew manager for the NxN MAC array: accepts one A/B matrix pair,
// streams them as time-skewed lanes, drains, then pulses done.
module systolic_operand_feeder
    import tpu_pkg::*;
#(
    parameter int OP_WIDTH = DEFAULT_OP_WIDTH,
    parameter int N        = DEFAULT_N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [N*N*OP_WIDTH-1:0] a_matrix,
    input  logic [N*N*OP_WIDTH-1:0] b_matrix,
    output logic [N*OP_WIDTH-1:0]   new_a_column,
    output logic [N*OP_WIDTH-1:0]   new_b_row,
    output logic                    feed_active,
    output logic                    acc_clear,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W      = $clog2(2 * N);
    localparam int FEED_LAST  = feed_cycles(N) - 1;
    localparam int DRAIN_LAST = drain_cycles(N) - 1;

    feeder_state_t           state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, t_sel;
    logic [N*N*OP_WIDTH-1:0] a_cap, b_cap, a_src, b_src;
    wire  [N*OP_WIDTH-1:0]   a_next, b_next;
    logic                    accept, lanes_load;
    logic                    feed_d, clr_d, busy_d, done_d;

    assign start_ready = (state_q == IDLE);
    assign accept      = start_valid && start_ready;

    // On the accept edge the captured copy is not loaded yet, so the t=0
    // lanes come straight from the inputs; afterwards look one cycle ahead.
    assign a_src = accept ? a_matrix : a_cap;
    assign b_src = accept ? b_matrix : b_cap;
    assign t_sel = accept ? '0 : cnt_q + CNT_W'(1);

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_lane_select #(
            .OP_WIDTH (OP_WIDTH),
            .N        (N),
            .CNT_W    (CNT_W),
            .LANE     (g),
            .COL_MAJOR(1'b0)
        ) u_a_sel (
            .matrix (a_src),
            .t      (t_sel),
            .element(a_next[g*OP_WIDTH +: OP_WIDTH])
        );

        skew_lane_select #(
            .OP_WIDTH (OP_WIDTH),
            .N        (N),
            .CNT_W    (CNT_W),
            .LANE     (g),
            .COL_MAJOR(1'b1)
        ) u_b_sel (
            .matrix (b_src),
            .t      (t_sel),
            .element(b_next[g*OP_WIDTH +: OP_WIDTH])
        );
    end

    // Next state, counter and next registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        feed_d     = 1'b0;
        clr_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        lanes_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = FEED;
                    cnt_d      = '0;
                    feed_d     = 1'b1;
                    clr_d      = 1'b1;
                    busy_d     = 1'b1;
                    lanes_load = 1'b1;
                end
            end
            FEED: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(FEED_LAST)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    feed_d     = 1'b1;
                    lanes_load = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            feed_active  <= 1'b0;
            acc_clear    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            new_a_column <= '0;
            new_b_row    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            feed_active  <= feed_d;
            acc_clear    <= clr_d;
            busy         <= busy_d;
            done         <= done_d;
            new_a_column <= lanes_load ? a_next : '0;
            new_b_row    <= lanes_load ? b_next : '0;
        end
    end

    // Hold a private copy of the job's matrices so the inputs may change after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: these data registers are reset on purpose so a fresh part never replays stale operands.
            a_cap <= '0;
            b_cap <= '0;
        end else if (accept) begin
            a_cap <= a_matrix;
            b_cap <= b_matrix;
        end
    end

endmodule
